// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the CPU load/store
//               port (fixed priority) and a DMA/debug requester that is
//               protected by a starvation counter and may lock short bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic                  dma_last,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int              c_waitW    = $clog2(MAX_WAIT + 1);
    localparam int              c_beatW    = $clog2(BURST_MAX + 1);
    localparam logic [c_waitW-1:0] c_maxWait  = c_waitW'(MAX_WAIT);
    localparam logic [c_beatW-1:0] c_burstMax = c_beatW'(BURST_MAX);
    localparam logic [c_beatW-1:0] c_firstBeat = c_beatW'(1);
    // A single-beat burst limit means a burst can never be held open
    localparam logic            c_burstEn  = (BURST_MAX > 1);

    typedef enum logic [0:0] {
        CPU_PRI   = 1'b0,
        DMA_BURST = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_waitW-1:0]   r_waitCnt;
    logic [c_beatW-1:0]   r_beatCnt;
    logic                 r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                 w_cpuReq;
    logic                 w_starved;
    logic                 w_dmaGnt;
    logic [c_beatW-1:0]   w_beatNext;

    assign w_cpuReq   = cpu_re | cpu_we;
    assign w_starved  = (r_waitCnt == c_maxWait);
    assign w_beatNext = r_beatCnt + c_firstBeat;

    // Grant decision: burst owns the port, otherwise CPU wins unless DMA is starved
    always_comb begin
        w_dmaGnt = 1'b0;
        if (r_state == DMA_BURST) begin
            w_dmaGnt = dma_req;
        end else begin
            w_dmaGnt = dma_req & (~w_cpuReq | w_starved);
        end
    end

    assign dma_gnt    = w_dmaGnt;
    assign cpu_stall  = w_cpuReq & w_dmaGnt;
    assign cpu_rdata  = mem_rdata;
    assign dma_rvalid = r_rvalid;
    assign dma_rdata  = r_rdata;

    // Memory mux: the granted DMA beat overrides the CPU; a stalled CPU store never reaches memory
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (w_dmaGnt) begin
            mem_re    = ~dma_we;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else begin
            mem_re    = cpu_re;
            mem_we    = cpu_we;
        end
    end

    // Burst FSM: enter on a granted non-last beat, leave on idle, last beat or beat limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= CPU_PRI;
            r_beatCnt <= '0;
        end else begin
            case (r_state)
                CPU_PRI: begin
                    if (w_dmaGnt && !dma_last && c_burstEn) begin
                        r_state   <= DMA_BURST;
                        r_beatCnt <= c_firstBeat;
                    end
                end
                DMA_BURST: begin
                    if (!dma_req) begin
                        r_state   <= CPU_PRI;
                        r_beatCnt <= '0;
                    end else if (dma_last || (w_beatNext == c_burstMax)) begin
                        r_state   <= CPU_PRI;
                        r_beatCnt <= '0;
                    end else begin
                        r_beatCnt <= w_beatNext;
                    end
                end
                default: begin
                    r_state   <= CPU_PRI;
                    r_beatCnt <= '0;
                end
            endcase
        end
    end

    // Starvation counter: counts denied DMA cycles, saturates, clears on any grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waitCnt <= '0;
        end else if (w_dmaGnt) begin
            r_waitCnt <= '0;
        end else if (dma_req && !w_starved) begin
            r_waitCnt <= r_waitCnt + c_waitW'(1);
        end
    end

    // DMA read return: capture data at the end of the grant cycle, valid for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_dmaGnt & ~dma_we;
            if (w_dmaGnt && !dma_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a behavioural data
//               memory; directed cycle vectors with hand-derived grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpuRe, cpuWe;
    logic [31:0] cpuAddr, cpuWdata, cpuRdata;
    logic        cpuStall;
    logic        dmaReq, dmaWe, dmaLast;
    logic [31:0] dmaAddr, dmaWdata;
    logic        dmaGnt, dmaRvalid;
    logic [31:0] dmaRdata;
    logic        memRe, memWe;
    logic [31:0] memAddr, memWdata, memRdata;

    logic [31:0] tbMem [0:63];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        gnt;
        logic        stall;
        logic        memRe;
        logic        memWe;
        logic [31:0] memAddr;
        logic        chkRd;
        logic [31:0] rd;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] rdQ[$];
    exp_t        monExp;

    dmem_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MAX_WAIT  (4),
        .BURST_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_re    (cpuRe),
        .cpu_we    (cpuWe),
        .cpu_addr  (cpuAddr),
        .cpu_wdata (cpuWdata),
        .cpu_rdata (cpuRdata),
        .cpu_stall (cpuStall),
        .dma_req   (dmaReq),
        .dma_we    (dmaWe),
        .dma_last  (dmaLast),
        .dma_addr  (dmaAddr),
        .dma_wdata (dmaWdata),
        .dma_gnt   (dmaGnt),
        .dma_rvalid(dmaRvalid),
        .dma_rdata (dmaRdata),
        .mem_re    (memRe),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_rdata (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, write at the clock edge
    assign memRdata = tbMem[memAddr[7:2]];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                tbMem[i] <= (i == 4) ? 32'hCAFE_0001 : (32'hA000_0000 + 32'(i));
            end
        end else if (memWe) begin
            tbMem[memAddr[7:2]] <= memWdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs after the edge and queue what the DUT must present
    task automatic cyc(input logic cRe, input logic cWe, input logic [31:0] cAddr,
                       input logic [31:0] cWd, input logic dReq, input logic dWe,
                       input logic dLast, input logic [31:0] dAddr, input logic [31:0] dWd,
                       input logic eGnt, input logic eStall);
        exp_t e;
        @(posedge clk);
        #1;
        cpuRe = cRe;  cpuWe = cWe;  cpuAddr = cAddr;  cpuWdata = cWd;
        dmaReq = dReq; dmaWe = dWe; dmaLast = dLast; dmaAddr = dAddr; dmaWdata = dWd;
        e.gnt   = eGnt;
        e.stall = eStall;
        if (eGnt) begin
            e.memRe   = ~dWe;
            e.memWe   = dWe;
            e.memAddr = dAddr;
        end else begin
            e.memRe   = cRe;
            e.memWe   = cWe;
            e.memAddr = cAddr;
        end
        e.chkRd = cRe & ~eStall;
        e.rd    = tbMem[cAddr[7:2]];
        expQ.push_back(e);
        if (eGnt && !dWe) rdQ.push_back(tbMem[dAddr[7:2]]);
    endtask

    // Monitor: per-cycle handshake/mux checks and read-return scoreboard
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            chk("dma_gnt",   32'(dmaGnt),   32'(monExp.gnt));
            chk("cpu_stall", 32'(cpuStall), 32'(monExp.stall));
            chk("mem_re",    32'(memRe),    32'(monExp.memRe));
            chk("mem_we",    32'(memWe),    32'(monExp.memWe));
            if (monExp.memRe || monExp.memWe) chk("mem_addr", memAddr, monExp.memAddr);
            if (monExp.chkRd) chk("cpu_rdata", cpuRdata, monExp.rd);
        end
        if (dmaRvalid) begin
            if (rdQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dma_rvalid: got 1 expected 0 (no read outstanding) at %0t", $time);
            end else begin
                chk("dma_rdata", dmaRdata, rdQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        cpuRe = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
        dmaReq = 0; dmaWe = 0; dmaLast = 0; dmaAddr = 0; dmaWdata = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst dma_rvalid", 32'(dmaRvalid), 32'd0);
        chk("rst dma_rdata",  dmaRdata,       32'd0);
        chk("rst dma_gnt",    32'(dmaGnt),    32'd0);
        cpuRe = 1; dmaReq = 1;
        #1;
        chk("rst gnt cpu busy", 32'(dmaGnt),   32'd0);
        chk("rst stall",        32'(cpuStall), 32'd0);
        cpuRe = 0;
        #1;
        chk("rst gnt cpu idle", 32'(dmaGnt), 32'd1);
        dmaReq = 0;
        @(negedge clk);
        reset = 1'b1;

        // DMA read with CPU idle: same-cycle grant, data next cycle
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h10, 32'h0, 1, 0);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0,  32'h0, 0, 0);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0,  32'h0, 0, 0);
        chk("dma_rdata hold", dmaRdata, 32'hCAFE_0001);

        // Continuous CPU loads: DMA write forced through on the 5th cycle
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 32'h40, 32'h0, 1, 1, 1, 32'h30, 32'h1111_2222, 0, 0);
        cyc(1, 0, 32'h40, 32'h0, 1, 1, 1, 32'h30, 32'h1111_2222, 1, 1);
        cyc(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0,  32'h0,         0, 0);
        chk("starved dma write", tbMem[12], 32'h1111_2222);

        // 6-beat read burst against busy CPU: 4 locked beats, release, starve, 2 beats
        for (int b = 0; b < 6; b++) begin
            int waits;
            logic [31:0] a;
            waits = (b == 0 || b == 4) ? 4 : 0;
            a = 32'h80 + 32'(4 * b);
            for (int w = 0; w < waits; w++)
                cyc(1, 0, 32'h44, 32'h0, 1, 0, (b == 5), a, 32'h0, 0, 0);
            cyc(1, 0, 32'h44, 32'h0, 1, 0, (b == 5), a, 32'h0, 1, 1);
        end
        cyc(1, 0, 32'h44, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // CPU store stalled by a DMA write to the same word; CPU value lands last
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 32'h40, 32'h0, 1, 1, 1, 32'h20, 32'hD0D0_D0D0, 0, 0);
        cyc(0, 1, 32'h20, 32'hC0C0_C0C0, 1, 1, 1, 32'h20, 32'hD0D0_D0D0, 1, 1);
        cyc(0, 1, 32'h20, 32'hC0C0_C0C0, 0, 0, 0, 32'h0,  32'h0,         0, 0);
        chk("dma wins store", tbMem[8], 32'hD0D0_D0D0);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("cpu store after stall", tbMem[8], 32'hC0C0_C0C0);

        // Reset on beat 2 of a burst with a read return pending
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h08, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        dmaAddr = 32'h0C;
        chk("beat2 rvalid", 32'(dmaRvalid), 32'd1);
        chk("beat2 gnt",    32'(dmaGnt),    32'd1);
        rdQ.delete();
        reset = 1'b0;
        #1;
        chk("rst burst rvalid", 32'(dmaRvalid), 32'd0);
        chk("rst burst rdata",  dmaRdata,       32'd0);
        cpuRe = 1;
        #1;
        chk("rst burst gnt",   32'(dmaGnt),   32'd0);
        chk("rst burst stall", 32'(cpuStall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 0, 32'h40, 32'h0, 1, 0, 0, 32'h0C, 32'h0, 0, 0);
        cyc(0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h0C, 32'h0, 1, 0);
        cyc(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0,  32'h0, 0, 0);
        cyc(0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  32'h0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;

        chk("expected cycles left", 32'(expQ.size()), 32'd0);
        chk("read returns left",    32'(rdQ.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
